uart_wb_master: RTL and testbench

UART_WB_MASTER -- requirements
Module: uart_wb_master

---
 rtl/uart_wb_master.sv | 169 ++++++++++++++++
 tb/tb_uart_wb_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// Byte-stream command bridge to a Wishbone classic master: 'W'/'R' commands with
// big-endian address/data bytes, answered with 'K', read data, or 'E' on timeout.
module uart_wb_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy_o
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

   localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
   localparam logic [7:0]  CmdWrite   = 8'h57;
   localparam logic [7:0]  CmdRead    = 8'h52;
   localparam logic [7:0]  RespOk     = 8'h4B;
   localparam logic [7:0]  RespErr    = 8'h45;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [1:0]  byteCnt_q, byteCnt_d;
   logic [15:0] waitCnt_q, waitCnt_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [31:0] rdat_q, rdat_d;
   logic        rdyEn_q;

   logic        rxAccept;
   logic        txAccept;
   logic        lastByte;
   logic [7:0]  respByte;

   // rdyEn_q keeps rx_ready low during reset and lets it rise on the first edge after release.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         byteCnt_q <= 2'd0;
         waitCnt_q <= 16'd0;
         adr_q     <= 32'h0;
         wdat_q    <= 32'h0;
         rdat_q    <= 32'h0;
         rdyEn_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         err_q     <= err_d;
         byteCnt_q <= byteCnt_d;
         waitCnt_q <= waitCnt_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         rdat_q    <= rdat_d;
         rdyEn_q   <= 1'b1;
      end
   end

   assign rx_ready = rdyEn_q && (state_q == IDLE || state_q == ADDR || state_q == DATA);
   assign rxAccept = rx_valid && rx_ready;
   assign tx_valid = (state_q == RESP);
   assign txAccept = tx_valid && tx_ready;
   assign lastByte = err_q || we_q || (byteCnt_q == 2'd3);

   always_comb begin
      respByte = RespOk;
      if (err_q) begin
         respByte = RespErr;
      end else if (!we_q) begin
         case (byteCnt_q)
            2'd0:    respByte = rdat_q[31:24];
            2'd1:    respByte = rdat_q[23:16];
            2'd2:    respByte = rdat_q[15:8];
            default: respByte = rdat_q[7:0];
         endcase
      end
   end

   assign tx_data   = tx_valid ? respByte : 8'h00;
   assign wbm_cyc_o = (state_q == BUS);
   assign wbm_stb_o = (state_q == BUS);
   assign wbm_we_o  = (state_q == BUS) && we_q;
   assign wbm_sel_o = (state_q == BUS) ? 4'hF : 4'h0;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = wdat_q;
   assign busy_o    = (state_q != IDLE);

   // Ack is checked before the wait counter so a late ack on the limit cycle still succeeds.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      err_d     = err_q;
      byteCnt_d = byteCnt_q;
      waitCnt_d = waitCnt_q;
      adr_d     = adr_q;
      wdat_d    = wdat_q;
      rdat_d    = rdat_q;
      case (state_q)
         IDLE: begin
            if (rxAccept && (rx_data == CmdWrite || rx_data == CmdRead)) begin
               we_d      = (rx_data == CmdWrite);
               byteCnt_d = 2'd0;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (rxAccept) begin
               adr_d     = {adr_q[23:0], rx_data};
               byteCnt_d = byteCnt_q + 2'd1;
               if (byteCnt_q == 2'd3) begin
                  byteCnt_d = 2'd0;
                  waitCnt_d = 16'd0;
                  state_d   = we_q ? DATA : BUS;
               end
            end
         end
         DATA: begin
            if (rxAccept) begin
               wdat_d    = {wdat_q[23:0], rx_data};
               byteCnt_d = byteCnt_q + 2'd1;
               if (byteCnt_q == 2'd3) begin
                  byteCnt_d = 2'd0;
                  waitCnt_d = 16'd0;
                  state_d   = BUS;
               end
            end
         end
         BUS: begin
            if (wbm_ack_i) begin
               rdat_d    = wbm_dat_i;
               err_d     = 1'b0;
               byteCnt_d = 2'd0;
               state_d   = RESP;
            end else if (waitCnt_q == TimeoutVal) begin
               err_d     = 1'b1;
               byteCnt_d = 2'd0;
               state_d   = RESP;
            end else begin
               waitCnt_d = waitCnt_q + 16'd1;
            end
         end
         RESP: begin
            if (txAccept) begin
               if (lastByte) begin
                  state_d = IDLE;
               end else begin
                  byteCnt_d = byteCnt_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_wb_master.sv
// Scoreboard bench for uart_wb_master: expected response bytes are queued as
// commands are driven and checked as the DUT emits them.
module tb_uart_wb_master;

   localparam int unsigned TimeoutCycles = 4;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        busy_o;

   int          compared   = 0;
   int          mismatched = 0;
   logic [7:0]  expQ[$];
   int          stallLeft  = 0;

   uart_wb_master #(.TIMEOUT(TimeoutCycles)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_we_o (wbm_we_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i),
      .busy_o   (busy_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b);
      bit accepted = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 20 && !accepted; i++) begin
         if (rx_ready) accepted = 1'b1;
         tick();
      end
      rx_valid = 1'b0;
      checkOutput("rxAccepted", accepted, 1'b1);
   endtask

   task automatic sendWord(input logic [31:0] w);
      sendByte(w[31:24]);
      sendByte(w[23:16]);
      sendByte(w[15:8]);
      sendByte(w[7:0]);
   endtask

   // ackWait < 0 means the slave never acks; expCycles is the required stb-high duration.
   task automatic applyStimulus(input int ackWait, input logic [31:0] rdata, input logic expWe,
                                input logic [31:0] expAdr, input logic [31:0] expDat, input int expCycles);
      bit seen = 1'b0;
      int n = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (wbm_stb_o) seen = 1'b1;
         else tick();
      end
      checkOutput("stbSeen", seen, 1'b1);
      if (!seen) return;
      checkOutput("cyc", wbm_cyc_o, 1'b1);
      checkOutput("adr", wbm_adr_o, expAdr);
      checkOutput("we", wbm_we_o, expWe);
      checkOutput("sel", wbm_sel_o, 4'hF);
      checkOutput("rxReadyInBus", rx_ready, 1'b0);
      if (expWe) checkOutput("datOut", wbm_dat_o, expDat);
      while (wbm_stb_o && n < 100) begin
         if (n == ackWait) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = rdata;
         end
         tick();
         wbm_ack_i = 1'b0;
         wbm_dat_i = 32'h0;
         n++;
         if (wbm_stb_o) checkOutput("adrStable", wbm_adr_o, expAdr);
      end
      checkOutput("stbCycles", n, expCycles);
      checkOutput("cycLowAfter", wbm_cyc_o, 1'b0);
   endtask

   task automatic waitDrain();
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (expQ.size() == 0 && !tx_valid) done = 1'b1;
         else tick();
      end
      checkOutput("txDrain", done, 1'b1);
   endtask

   task automatic pushWord(input logic [31:0] w);
      expQ.push_back(w[31:24]);
      expQ.push_back(w[23:16]);
      expQ.push_back(w[15:8]);
      expQ.push_back(w[7:0]);
   endtask

   // Response monitor: applies backpressure, checks hold-while-stalled and pops the scoreboard.
   initial begin
      bit         prevValid = 1'b0;
      bit         prevHs    = 1'b0;
      logic [7:0] prevData  = 8'h00;
      bit         hs;
      logic [7:0] exp;
      tx_ready = 1'b1;
      forever begin
         tick();
         if (stallLeft > 0 && tx_valid) begin
            tx_ready = 1'b0;
            stallLeft--;
         end else begin
            tx_ready = 1'b1;
         end
         if (tx_valid) begin
            checkOutput("rxReadyInResp", rx_ready, 1'b0);
            if (prevValid && !prevHs) checkOutput("txHold", tx_data, prevData);
         end
         hs = tx_valid && tx_ready;
         if (hs) begin
            checkOutput("txExpected", expQ.size() != 0, 1'b1);
            if (expQ.size() != 0) begin
               exp = expQ.pop_front();
               checkOutput("txByte", tx_data, exp);
            end
         end
         prevValid = tx_valid;
         prevHs    = hs;
         prevData  = tx_data;
      end
   end

   initial begin
      wb_rst_i  = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      wbm_dat_i = 32'h0;
      wbm_ack_i = 1'b0;
      #2;
      checkOutput("rstRxReady", rx_ready, 1'b0);
      checkOutput("rstBusy", busy_o, 1'b0);
      checkOutput("rstTxValid", tx_valid, 1'b0);
      checkOutput("rstTxData", tx_data, 8'h00);
      checkOutput("rstCyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b000);
      checkOutput("rstSel", wbm_sel_o, 4'h0);
      checkOutput("rstAdr", wbm_adr_o, 32'h0);
      checkOutput("rstDat", wbm_dat_o, 32'h0);
      tick();
      tick();
      wb_rst_i = 1'b0;
      checkOutput("rxReadyBeforeEdge", rx_ready, 1'b0);
      tick();
      checkOutput("rxReadyAfterEdge", rx_ready, 1'b1);

      $display("[TB] write with 3 wait states");
      expQ.push_back(8'h4B);
      sendByte(8'h57);
      checkOutput("busyAfterCmd", busy_o, 1'b1);
      sendWord(32'h1234_5678);
      sendWord(32'hDEAD_BEEF);
      applyStimulus(3, 32'h0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 4);
      waitDrain();

      $display("[TB] read with zero-wait ack");
      pushWord(32'hCAFE_F00D);
      sendByte(8'h52);
      sendWord(32'h0000_0010);
      applyStimulus(0, 32'hCAFE_F00D, 1'b0, 32'h0000_0010, 32'h0, 1);
      waitDrain();

      $display("[TB] read timeout");
      expQ.push_back(8'h45);
      sendByte(8'h52);
      sendWord(32'h0000_0044);
      applyStimulus(-1, 32'h0, 1'b0, 32'h0000_0044, 32'h0, TimeoutCycles + 1);
      waitDrain();

      $display("[TB] ack exactly on the timeout cycle");
      pushWord(32'h0BAD_F00D);
      sendByte(8'h52);
      sendWord(32'h0000_0048);
      applyStimulus(TimeoutCycles, 32'h0BAD_F00D, 1'b0, 32'h0000_0048, 32'h0, TimeoutCycles + 1);
      waitDrain();

      $display("[TB] stray ack in IDLE");
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      tick();
      checkOutput("strayAckBusy", busy_o, 1'b0);
      checkOutput("strayAckTx", tx_valid, 1'b0);

      $display("[TB] garbage and backpressure");
      sendByte(8'h00);
      checkOutput("junk00Idle", busy_o, 1'b0);
      sendByte(8'hFF);
      checkOutput("junkFFIdle", busy_o, 1'b0);
      pushWord(32'h0123_4567);
      stallLeft = 10;
      sendByte(8'h52);
      sendWord(32'h0000_0020);
      applyStimulus(1, 32'h0123_4567, 1'b0, 32'h0000_0020, 32'h0, 2);
      waitDrain();

      $display("[TB] reset during bus cycle");
      sendByte(8'h57);
      sendWord(32'hAAAA_0000);
      sendWord(32'h5555_1111);
      for (int i = 0; i < 20 && !wbm_stb_o; i++) tick();
      checkOutput("stbBeforeReset", wbm_stb_o, 1'b1);
      wb_rst_i = 1'b1;
      #1;
      checkOutput("rstAbortCycStb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      checkOutput("rstAbortBusy", busy_o, 1'b0);
      tick();
      tick();
      wb_rst_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("noTxAfterReset", tx_valid, 1'b0);
      end

      expQ.push_back(8'h4B);
      sendByte(8'h57);
      sendWord(32'h0000_00C0);
      sendWord(32'h8765_4321);
      applyStimulus(2, 32'h0, 1'b1, 32'h0000_00C0, 32'h8765_4321, 3);
      waitDrain();
      checkOutput("finalQueueEmpty", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
